// File: rtl/pw_doppler_sequencer.sv
// ---- pw_doppler_sequencer : pulsed-wave Doppler PRF timing sequencer (rev 1.0) ----
`default_nettype none
`timescale 1ns/1ps

module pw_doppler_sequencer #(
  parameter int HALF_PER_F0  = 16,
  parameter int HALF_PER_F1  = 8,
  parameter int HALF_PER_F2  = 4,
  parameter int HALF_PER_F3  = 2,
  parameter int BURST_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [1:0]  TX_ON,
  input  logic        RX_ON,
  input  logic [1:0]  FREQUENCY,
  input  logic [7:0]  GATE_LENGTH,
  input  logic [15:0] STATE0VALUE,
  input  logic [15:0] STATE1VALUE,
  input  logic [15:0] STATE2VALUE,
  input  logic [15:0] STATERVALUE,
  output logic        TX_P,
  output logic        TX_N,
  output logic        DEMOD_EN,
  output logic        SAMPLE_GATE,
  output logic        PRF_TICK,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TX     = 3'd1,
    ST_DELAY1 = 3'd2,
    ST_DEMOD  = 3'd3,
    ST_DELAY2 = 3'd4,
    ST_RETX   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ph_q, ph_d;
  logic [1:0]  freq_q, freq_d;
  logic [7:0]  gate_q, gate_d;
  logic [15:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, sr_q, sr_d;
  logic        tx_p_q, tx_p_d, tx_n_q, tx_n_d;
  logic        demod_en_q, demod_en_d, sample_gate_q, sample_gate_d;
  logic        prf_tick_q, prf_tick_d;

  logic [15:0] half_cur, half_nxt, tx_last, ph_last, timed_val, timed_last;
  logic        done, load;

  function automatic logic [15:0] half_of(input logic [1:0] code);
    case (code)
      2'd0:    half_of = 16'(HALF_PER_F0);
      2'd1:    half_of = 16'(HALF_PER_F1);
      2'd2:    half_of = 16'(HALF_PER_F2);
      default: half_of = 16'(HALF_PER_F3);
    endcase
  endfunction

  always_comb begin
    half_cur = half_of(freq_q);
    tx_last  = 16'((32'(half_cur) * 32'(BURST_CYCLES) * 32'd2) - 32'd1);
    ph_last  = (half_cur << 1) - 16'd1;

    case (state_q)
      ST_DELAY1: timed_val = s0_q;
      ST_DEMOD:  timed_val = s1_q;
      ST_DELAY2: timed_val = s2_q;
      ST_RETX:   timed_val = sr_q;
      default:   timed_val = 16'd0;
    endcase
    // A programmed length of zero still occupies one cycle.
    timed_last = (timed_val == 16'd0) ? 16'd0 : timed_val - 16'd1;
    done       = (state_q == ST_TX) ? (cnt_q == tx_last) : (cnt_q == timed_last);

    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    ph_d    = ph_q;
    freq_d  = freq_q;
    gate_d  = gate_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    sr_d    = sr_q;
    load    = 1'b0;

    if (!ENABLE) begin
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
      ph_d    = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: load = 1'b1;
        ST_TX: begin
          if (done) begin
            state_d = ST_DELAY1;
            cnt_d   = 16'd0;
            ph_d    = 16'd0;
          end else begin
            ph_d = (ph_q == ph_last) ? 16'd0 : ph_q + 16'd1;
          end
        end
        ST_DELAY1: if (done) begin state_d = ST_DEMOD;  cnt_d = 16'd0; end
        ST_DEMOD:  if (done) begin state_d = ST_DELAY2; cnt_d = 16'd0; end
        ST_DELAY2: if (done) begin state_d = ST_RETX;   cnt_d = 16'd0; end
        ST_RETX:   if (done) load = 1'b1;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          ph_d    = 16'd0;
        end
      endcase
    end

    // Burst start: snapshot the register map so mid-period writes wait a period.
    if (load) begin
      state_d = ST_TX;
      cnt_d   = 16'd0;
      ph_d    = 16'd0;
      freq_d  = FREQUENCY;
      gate_d  = GATE_LENGTH;
      s0_d    = STATE0VALUE;
      s1_d    = STATE1VALUE;
      s2_d    = STATE2VALUE;
      sr_d    = STATERVALUE;
    end

    half_nxt      = half_of(freq_d);
    tx_p_d        = (state_d == ST_TX) && TX_ON[0] && (ph_d <  half_nxt);
    tx_n_d        = (state_d == ST_TX) && TX_ON[1] && (ph_d >= half_nxt);
    demod_en_d    = (state_d == ST_DEMOD) && RX_ON;
    sample_gate_d = demod_en_d && ({8'd0, gate_d} > cnt_d);
    prf_tick_d    = load;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      ph_q          <= 16'd0;
      freq_q        <= 2'd0;
      gate_q        <= 8'd0;
      s0_q          <= 16'd0;
      s1_q          <= 16'd0;
      s2_q          <= 16'd0;
      sr_q          <= 16'd0;
      tx_p_q        <= 1'b0;
      tx_n_q        <= 1'b0;
      demod_en_q    <= 1'b0;
      sample_gate_q <= 1'b0;
      prf_tick_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ph_q          <= ph_d;
      freq_q        <= freq_d;
      gate_q        <= gate_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      sr_q          <= sr_d;
      tx_p_q        <= tx_p_d;
      tx_n_q        <= tx_n_d;
      demod_en_q    <= demod_en_d;
      sample_gate_q <= sample_gate_d;
      prf_tick_q    <= prf_tick_d;
    end
  end

  assign TX_P        = tx_p_q;
  assign TX_N        = tx_n_q;
  assign DEMOD_EN    = demod_en_q;
  assign SAMPLE_GATE = sample_gate_q;
  assign PRF_TICK    = prf_tick_q;
  assign STATE       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pw_doppler_sequencer.sv
// ---- tb_pw_doppler_sequencer : timeline-model bench for the PW Doppler sequencer (rev 1.0) ----
`default_nettype none
`timescale 1ns/1ps

module tb_pw_doppler_sequencer;

  localparam int HP0 = 16, HP1 = 8, HP2 = 4, HP3 = 2, BURST = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic [1:0]  TX_ON = 2'b00;
  logic        RX_ON = 1'b0;
  logic [1:0]  FREQUENCY = 2'd0;
  logic [7:0]  GATE_LENGTH = 8'd0;
  logic [15:0] STATE0VALUE = 16'd0, STATE1VALUE = 16'd0, STATE2VALUE = 16'd0, STATERVALUE = 16'd0;
  logic        TX_P, TX_N, DEMOD_EN, SAMPLE_GATE, PRF_TICK;
  logic [2:0]  STATE;

  pw_doppler_sequencer #(
    .HALF_PER_F0(HP0), .HALF_PER_F1(HP1), .HALF_PER_F2(HP2), .HALF_PER_F3(HP3),
    .BURST_CYCLES(BURST)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .TX_ON(TX_ON), .RX_ON(RX_ON),
    .FREQUENCY(FREQUENCY), .GATE_LENGTH(GATE_LENGTH),
    .STATE0VALUE(STATE0VALUE), .STATE1VALUE(STATE1VALUE),
    .STATE2VALUE(STATE2VALUE), .STATERVALUE(STATERVALUE),
    .TX_P(TX_P), .TX_N(TX_N), .DEMOD_EN(DEMOD_EN), .SAMPLE_GATE(SAMPLE_GATE),
    .PRF_TICK(PRF_TICK), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int half_of(input logic [1:0] f);
    case (f)
      2'd0: return HP0;
      2'd1: return HP1;
      2'd2: return HP2;
      default: return HP3;
    endcase
  endfunction

  function automatic int atleast1(input logic [15:0] v);
    return (v == 16'd0) ? 1 : int'(v);
  endfunction

  // Model: one offset into the PRF period; outputs derived arithmetically from it.
  bit m_run = 0;
  int m_t = 0, m_per = 1, m_h = 1, m_ttx = 1, m_a = 1, m_b = 1, m_c = 1, m_r = 1, m_g = 0;
  logic e_p = 0, e_n = 0, e_den = 0, e_sg = 0, e_tick = 0;
  logic [2:0] e_st = 3'd0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_run = 0;
    end else if (!ENABLE) begin
      m_run = 0;
    end else if (!m_run || m_t == m_per - 1) begin
      m_run = 1;
      m_t   = 0;
      m_h   = half_of(FREQUENCY);
      m_ttx = 2 * m_h * BURST;
      m_a   = atleast1(STATE0VALUE);
      m_b   = atleast1(STATE1VALUE);
      m_c   = atleast1(STATE2VALUE);
      m_r   = atleast1(STATERVALUE);
      m_g   = int'(GATE_LENGTH);
      m_per = m_ttx + m_a + m_b + m_c + m_r;
    end else begin
      m_t++;
    end

    e_p = 0; e_n = 0; e_den = 0; e_sg = 0; e_tick = 0; e_st = 3'd0;
    if (m_run) begin
      int u;
      e_tick = (m_t == 0);
      u = m_t;
      if (u < m_ttx) begin
        e_st = 3'd1;
        e_p  = TX_ON[0] && ((u % (2 * m_h)) <  m_h);
        e_n  = TX_ON[1] && ((u % (2 * m_h)) >= m_h);
      end else begin
        u -= m_ttx;
        if (u < m_a) e_st = 3'd2;
        else begin
          u -= m_a;
          if (u < m_b) begin
            e_st  = 3'd3;
            e_den = RX_ON;
            e_sg  = RX_ON && (u < m_g);
          end else begin
            u -= m_b;
            e_st = (u < m_c) ? 3'd4 : 3'd5;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("tx_p", TX_P, e_p);
    chk("tx_n", TX_N, e_n);
    chk("demod_en", DEMOD_EN, e_den);
    chk("sample_gate", SAMPLE_GATE, e_sg);
    chk("prf_tick", PRF_TICK, e_tick);
    chk("state", STATE, e_st);
  end

  task automatic measure(output int gap, output int tx, output int d1, output int dm,
                         output int den, output int sg, output int tp, output int tn);
    int n;
    gap = 0; tx = 0; d1 = 0; dm = 0; den = 0; sg = 0; tp = 0; tn = 0;
    n = 0;
    do begin @(negedge CLK); n++; end while (PRF_TICK !== 1'b1 && n < 2000);
    if (PRF_TICK !== 1'b1) begin
      chk("tick_timeout", 0, 1);
      return;
    end
    do begin
      gap++;
      if (STATE == 3'd1) tx++;
      if (STATE == 3'd2) d1++;
      if (STATE == 3'd3) dm++;
      den += int'(DEMOD_EN);
      sg  += int'(SAMPLE_GATE);
      tp  += int'(TX_P);
      tn  += int'(TX_N);
      @(negedge CLK);
    end while (PRF_TICK !== 1'b1 && gap < 2000);
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (STATE !== s && n < 2000) begin @(negedge CLK); n++; end
    if (STATE !== s) chk("wait_state", STATE, s);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_drives"}, {TX_P, TX_N, DEMOD_EN, SAMPLE_GATE, PRF_TICK}, 5'd0);
    chk({tag, "_state"}, STATE, 3'd0);
  endtask

  int gap, tx, d1, dm, den, sg, tp, tn;

  initial begin
    ENABLE = 1'b1; FREQUENCY = 2'd2; TX_ON = 2'b11; RX_ON = 1'b1;
    STATE0VALUE = 16'd10; STATE1VALUE = 16'd20; STATE2VALUE = 16'd5; STATERVALUE = 16'd100;
    GATE_LENGTH = 8'd8;
    repeat (3) @(negedge CLK);
    chk_all_zero("in_reset");
    RESET_N = 1'b1;
    #1 chk("idle_after_release", STATE, 3'd0);
    @(negedge CLK);
    chk("first_tick", PRF_TICK, 1'b1);
    chk("first_state_tx", STATE, 3'd1);
    chk("first_txp", {TX_P, TX_N}, 2'b10);

    measure(gap, tx, d1, dm, den, sg, tp, tn);
    chk("base_gap", gap, 167);
    chk("base_tx_len", tx, 32);
    chk("base_delay1", d1, 10);
    chk("base_demod", dm, 20);
    chk("base_demod_en", den, 20);
    chk("base_gate", sg, 8);
    chk("base_txp", tp, 16);
    chk("base_txn", tn, 16);

    GATE_LENGTH = 8'd50;
    measure(gap, tx, d1, dm, den, sg, tp, tn);
    chk("clip_gate", sg, 20);
    chk("clip_gap", gap, 167);

    STATE0VALUE = 16'd0; GATE_LENGTH = 8'd0;
    measure(gap, tx, d1, dm, den, sg, tp, tn);
    chk("zero_delay1", d1, 1);
    chk("zero_gate", sg, 0);
    chk("zero_gap", gap, 158);

    STATE0VALUE = 16'd10; GATE_LENGTH = 8'd8;
    wait_state(3'd4);
    STATE1VALUE = 16'd40;
    measure(gap, tx, d1, dm, den, sg, tp, tn);
    chk("s1w_demod", dm, 40);
    chk("s1w_demod_en", den, 40);
    chk("s1w_gap", gap, 187);

    STATE1VALUE = 16'd20; RX_ON = 1'b0; TX_ON = 2'b01;
    measure(gap, tx, d1, dm, den, sg, tp, tn);
    chk("rxoff_demod_en", den, 0);
    chk("rxoff_gate", sg, 0);
    chk("txon01_txn", tn, 0);
    chk("txon01_txp", tp, 16);
    chk("rxoff_gap", gap, 167);

    RX_ON = 1'b1; TX_ON = 2'b11;
    wait_state(3'd1);
    repeat (5) @(negedge CLK);
    ENABLE = 1'b0;
    @(negedge CLK);
    chk_all_zero("en_drop");
    repeat (3) @(negedge CLK);
    chk_all_zero("en_low_hold");
    ENABLE = 1'b1;
    @(negedge CLK);
    chk("reenable_tick", PRF_TICK, 1'b1);
    chk("reenable_state", STATE, 3'd1);

    wait_state(3'd3);
    repeat (3) @(negedge CLK);
    chk("pre_reset_demod_en", DEMOD_EN, 1'b1);
    #1 RESET_N = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    #1 chk("idle_after_rerelease", STATE, 3'd0);
    @(negedge CLK);
    chk("restart_tick", PRF_TICK, 1'b1);
    repeat (200) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
